// File: rtl/msg_schedule.sv
// SHA-256 message schedule: captures a 512-bit block and streams W[0..ROUNDS-1]
// over valid/ready using a 16-word sliding window.
module msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] M,
  input  logic         finish,
  input  logic         w_ready,
  output logic [31:0]  w,
  output logic         w_valid,
  output logic [5:0]   t_index,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] window [16];
  logic [31:0] w_next;
  logic        accept;

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w      = window[0];
  assign accept = w_valid & w_ready;
  assign w_next = s1(window[14]) + window[9]
                + s0(window[1]) + window[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      t_index <= '0;
      w_valid <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 16; i++)
        window[i] <= '0;
    end else if (finish) begin
      state   <= IDLE;
      t_index <= '0;
      w_valid <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < 16; i++)
        window[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++)
              window[i] <= M[511-32*i -: 32];
            t_index <= '0;
            w_valid <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            for (int i = 0; i < 15; i++)
              window[i] <= window[i+1];
            window[15] <= w_next;
            // t_index holds at the last word so it never passes ROUNDS-1
            if (t_index == LAST) begin
              w_valid <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              t_index <= t_index + 6'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Directed bench for msg_schedule: "abc" block, stall, ignored start,
// abort, back-to-back blocks and asynchronous reset.
module tb_msg_schedule;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         finish = 1'b0;
  logic         w_ready = 1'b0;
  logic [511:0] M = '0;
  logic [31:0]  w;
  logic         w_valid;
  logic [5:0]   t_index;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [31:0] ew [64];

  localparam logic [511:0] ABC =
    {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK2 =
    {32'h12345678, {14{32'hffffffff}}, 32'h80000000};

  always #5 clk = ~clk;

  msg_schedule #(.ROUNDS(64)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .M(M),
    .finish(finish),
    .w_ready(w_ready),
    .w(w),
    .w_valid(w_valid),
    .t_index(t_index),
    .done(done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x,
                                       input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic calc(input logic [511:0] m);
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++)
      ew[i] = m[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      a = rotr(ew[i-15], 7) ^ rotr(ew[i-15], 18) ^ (ew[i-15] >> 3);
      b = rotr(ew[i-2], 17) ^ rotr(ew[i-2], 19) ^ (ew[i-2] >> 10);
      ew[i] = b + ew[i-7] + a + ew[i-16];
    end
  endtask

  task automatic do_start(input logic [511:0] m);
    M = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int n, input int stall_t,
                     input int start_t, input bit abc);
    int t = 0;
    int st = 0;
    int cyc = 0;
    bit pulsed = 0;
    while (t < n && cyc < 400) begin
      chk("w_valid", 32'(w_valid), 32'd1);
      chk("t_index", 32'(t_index), 32'(t));
      chk("w", w, ew[t]);
      if (abc) begin
        case (t)
          0:  chk("abc_w0", w, 32'h61626380);
          15: chk("abc_w15", w, 32'h00000018);
          16: chk("abc_w16", w, 32'h61626380);
          17: chk("abc_w17", w, 32'h000f0000);
          18: chk("abc_w18", w, 32'h7da86405);
          63: chk("abc_w63", w, 32'h12b1edeb);
          default: ;
        endcase
      end
      w_ready = !(t == stall_t && st < 5);
      if (t == stall_t && st < 5) st++;
      if (t == start_t && !pulsed) begin
        start = 1'b1;
        M = BLK2;
        pulsed = 1;
      end
      @(negedge clk);
      start = 1'b0;
      if (w_ready) t++;
      cyc++;
    end
    w_ready = 1'b0;
    if (cyc >= 400) chk("timeout", 32'(t), 32'(n));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(w_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_t", 32'(t_index), 32'd0);
    chk("rst_w", w, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_valid", 32'(w_valid), 32'd0);

    // abc block with stall at t=20 and stray start at t=30
    calc(ABC);
    do_start(ABC);
    run(64, 20, 30, 1);
    chk("done1", 32'(done), 32'd1);
    chk("done1_valid", 32'(w_valid), 32'd0);
    @(negedge clk);
    chk("done1_off", 32'(done), 32'd0);

    // back-to-back block, then abort with start asserted
    calc(BLK2);
    do_start(BLK2);
    chk("b2_w0", w, 32'h12345678);
    run(10, -1, -1, 0);
    finish = 1'b1;
    start = 1'b1;
    M = ABC;
    w_ready = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    start = 1'b0;
    w_ready = 1'b0;
    chk("abort_valid", 32'(w_valid), 32'd0);
    chk("abort_t", 32'(t_index), 32'd0);
    chk("abort_w", w, 32'd0);
    repeat (3) begin
      chk("abort_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("abort_idle", 32'(w_valid), 32'd0);

    // clean rerun after abort; start during DONE is ignored
    calc(ABC);
    do_start(ABC);
    run(64, -1, -1, 1);
    chk("done2", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done", 32'(w_valid), 32'd0);
    chk("done2_off", 32'(done), 32'd0);

    // asynchronous reset mid-run
    do_start(ABC);
    run(5, -1, -1, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(w_valid), 32'd0);
    chk("arst_w", w, 32'd0);
    chk("arst_t", 32'(t_index), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(w_valid), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
